uart_txd_quad: RTL and testbench
================================

// Module: uart_txd_quad
// PURPOSE
// - UART transmitter for the LC3 serial link: sends a 4-byte burst (t1..t4) on txd, 8N1 or 8-bit + parity + 1 stop.
// - Bit timing and parity rule are the mirror of the RXD receiver, so a txd->rxd loopback fills r1..r4 in the same order.
// - Sits between the LC3 host-side logic and the serial pin; owns its own baud-tick divider.
// PARAMETERS
// - TICK_DIV  16'h0032  clocks per oversample tick (same meaning as the receiver's times)
// - OVS       8         ticks per bit; bit period BIT_CLKS = TICK_DIV*OVS clocks (default 400)
// PORTS
// - clk          in   1  system clock; single clock domain
// - rst_n        in   1  asynchronous, active-low reset
// - parity_en    in   1  1 = append parity bit after data
// - parity_kind  in   1  1 = odd, 0 = even
// - start        in   1  request a 4-byte burst; sampled only when busy=0
// - t1,t2,t3,t4  in   8  payload bytes; t1 sent first
// - txd          out  1  serial line, idle high, registered
// - busy         out  1  1 from the cycle after start is accepted until burst completes
// - done         out  1  one-cycle pulse when the last stop bit ends
// BEHAVIOUR
// - Reset (async): txd=1, busy=0, done=0, FSM=IDLE, tick divider, bit counter, byte index cleared.
// - Reset mid-burst: txd returns to 1 immediately; burst abandoned, no done pulse.
// - Acceptance: start=1 && busy=0 at rising edge N -> t1..t4, parity_en, parity_kind latched;
//   busy=1 and txd=0 (start bit) from N+1. Input changes after N have no effect on the burst.
// - start while busy=1: ignored, not queued.
// - Tick divider runs only while busy; restarts at 0 on acceptance; each bit held exactly BIT_CLKS clocks.
// - FSM: IDLE -> START (txd=0) -> DATA (8 bits, LSB first) -> PARITY (only if parity_en)
//   -> STOP (txd=1) -> START of next byte, or DONE after byte 4.
// - Byte order t1,t2,t3,t4; byte index 2-bit, no gaps between bytes (next start bit follows stop directly).
// - Parity bit = parity_kind ^ (^data): odd parity makes total count of 1s in data+parity odd.
// - Burst length: 4*10*BIT_CLKS clocks (parity off) or 4*11*BIT_CLKS (parity on), measured N+1 to end of last stop.
// - DONE: in the cycle after the last stop bit ends: done=1, busy=0, txd=1, FSM->IDLE.
//   start=1 in that same cycle is accepted (busy already 0); back-to-back bursts keep 1 stop bit minimum.
// - txd only changes on bit boundaries; no glitches, no intermediate values within a bit.
// TESTING (TICK_DIV=2, OVS=8 -> BIT_CLKS=16)
// - Reset: hold rst_n=0 -> txd=1, busy=0, done=0; release, no start -> txd stays 1 for 1000 clks.
// - 8N1 shape: parity_en=0, t1=8'h55, start -> txd=0 for 16 clks, then 1,0,1,0,1,0,1,0 each 16 clks, stop 1;
//   busy high exactly 640 clks, done pulses once at clk 641.
// - Parity: t1=8'h01 odd -> parity bit 0; even -> 1; t1=8'h03 even -> 0; burst length 704 clks.
// - Loopback to RXD (same TICK_DIV, parity_en=1, odd): t1..t4=A5,3C,0F,F0 -> r1..r4=A5,3C,0F,F0, fr=1.
// - Start while busy: pulse start at clk 100 of a burst with new bytes -> waveform unchanged, single done.
// - Reset mid-burst: rst_n=0 during data bit 3 of byte 2 -> txd=1 same cycle, no done; new start sends full burst.

Source files
------------

// File: rtl/uart_txd_quad_if.sv
// uart_txd_quad_if: host-side bundle for the quad-byte UART transmitter.
// Host (master) supplies burst request and payload; transmitter (slave) drives line and status.
interface uart_txd_quad_if;
    logic       start;
    logic       parity_en;
    logic       parity_kind;
    logic [7:0] t1, t2, t3, t4;
    logic       txd;
    logic       busy;
    logic       done;
    modport master (output start, parity_en, parity_kind, t1, t2, t3, t4, input txd, busy, done);
    modport slave  (input start, parity_en, parity_kind, t1, t2, t3, t4, output txd, busy, done);
endinterface

// File: rtl/uart_txd_quad.sv
// uart_txd_quad: sends a 4-byte burst t1..t4 on txd, 8N1 or 8 data + parity + 1 stop,
// with bit timing TICK_DIV*OVS clocks matching the companion RXD receiver.
module uart_txd_quad #(
    parameter logic [15:0] TICK_DIV = 16'h0032,
    parameter int unsigned OVS      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_txd_quad_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    logic [2:0]  state;
    logic [15:0] tick_cnt;
    logic [7:0]  ovs_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] payload;
    logic        par_en;
    logic        par_kind;
    logic [7:0]  cur;
    logic        tick_end;
    logic        bit_end;
    assign cur      = payload[{byte_idx, 3'b000} +: 8];
    assign tick_end = tick_cnt == TICK_DIV - 16'd1;
    assign bit_end  = tick_end && ovs_cnt == 8'(OVS - 1);
    assign bus.busy = state != S_IDLE;
    // txd is only ever updated on acceptance or at a bit boundary, so it never glitches mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            ovs_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            payload  <= '0;
            par_en   <= 1'b0;
            par_kind <= 1'b0;
            bus.txd  <= 1'b1;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.start) begin
                    payload  <= {bus.t4, bus.t3, bus.t2, bus.t1};
                    par_en   <= bus.parity_en;
                    par_kind <= bus.parity_kind;
                    state    <= S_START;
                    tick_cnt <= '0;
                    ovs_cnt  <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    bus.txd  <= 1'b0;
                end
            end else begin
                tick_cnt <= tick_end ? '0 : tick_cnt + 16'd1;
                if (tick_end)
                    ovs_cnt <= bit_end ? '0 : ovs_cnt + 8'd1;
                if (bit_end) begin
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            bus.txd <= cur[0];
                        end
                        S_DATA: begin
                            if (bit_idx == 3'd7) begin
                                state   <= par_en ? S_PARITY : S_STOP;
                                bus.txd <= par_en ? par_kind ^ (^cur) : 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                bus.txd <= cur[bit_idx + 3'd1];
                            end
                        end
                        S_PARITY: begin
                            state   <= S_STOP;
                            bus.txd <= 1'b1;
                        end
                        S_STOP: begin
                            if (byte_idx == 2'd3) begin
                                state    <= S_IDLE;
                                bus.done <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                                state    <= S_START;
                                bus.txd  <= 1'b0;
                            end
                        end
                        default: begin
                            state   <= S_IDLE;
                            bus.txd <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_txd_quad.sv
// tb_uart_txd_quad: directed scenario bench for uart_txd_quad with TICK_DIV=2, OVS=8 (16-clock bits).
module tb_uart_txd_quad;
    localparam int BC = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    uart_txd_quad_if bus();
    uart_txd_quad #(.TICK_DIV(16'd2), .OVS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int compared = 0;
    int mismatched = 0;
    logic cap_txd [0:1499];
    logic cap_busy [0:1499];
    logic cap_done [0:1499];
    int pulse_k = -1;
    int pulse_len = 0;
    int rst_k = -1;
    logic [31:0] pulse_bytes = '0;
    logic rst_txd, rst_busy;

    // Reference line level k clocks after acceptance, derived from the frame layout alone
    function automatic logic exp_txd(input int k, input logic [31:0] b, input logic pe, input logic pk);
        int nb, bi, pos;
        logic [7:0] d;
        nb = pe ? 11 : 10;
        bi = k / BC;
        if (k < 0 || bi >= 4 * nb) return 1'b1;
        d = b[(bi / nb) * 8 +: 8];
        pos = bi % nb;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[pos - 1];
        if (pos == 9 && pe) return pk ^ (^d);
        return 1'b1;
    endfunction

    task automatic capture(input logic [31:0] b, input logic pe, input logic pk, input int n);
        {bus.t4, bus.t3, bus.t2, bus.t1} = b;
        bus.parity_en = pe;
        bus.parity_kind = pk;
        bus.start = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            cap_txd[k] = bus.txd;
            cap_busy[k] = bus.busy;
            cap_done[k] = bus.done;
            if (k == pulse_k) begin
                {bus.t4, bus.t3, bus.t2, bus.t1} = pulse_bytes;
                bus.start = 1'b1;
            end
            if (k == pulse_k + pulse_len) bus.start = 1'b0;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                rst_txd = bus.txd;
                rst_busy = bus.busy;
            end
        end
        pulse_k = -1;
        pulse_len = 0;
        rst_k = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.parity_en = 1'b0;
        bus.parity_kind = 1'b0;
        {bus.t4, bus.t3, bus.t2, bus.t1} = '0;
        repeat (3) @(negedge clk);
        compared++; if (bus.txd !== 1'b1) begin mismatched++; $display("FAIL reset_txd: got %b expected 1", bus.txd); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        compared++; if (bus.done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst_n = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            compared++;
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                mismatched++;
                $display("FAIL idle_line clk %0d: got txd=%b busy=%b done=%b expected 1/0/0", k, bus.txd, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_8n1();
        logic [31:0] b = 32'h8100FF55;
        int nbusy = 0, ndone = 0;
        capture(b, 1'b0, 1'b0, 660);
        for (int k = 0; k < 660; k++) begin
            compared++;
            if (cap_txd[k] !== exp_txd(k, b, 1'b0, 1'b0)) begin
                mismatched++;
                $display("FAIL 8n1_txd clk %0d: got %b expected %b", k, cap_txd[k], exp_txd(k, b, 1'b0, 1'b0));
            end
            nbusy += int'(cap_busy[k] === 1'b1);
            ndone += int'(cap_done[k] === 1'b1);
        end
        compared++; if (nbusy != 640) begin mismatched++; $display("FAIL 8n1_busy_len: got %0d expected 640", nbusy); end
        compared++; if (ndone != 1) begin mismatched++; $display("FAIL 8n1_done_count: got %0d expected 1", ndone); end
        compared++; if (cap_done[640] !== 1'b1) begin mismatched++; $display("FAIL 8n1_done_pos: got %b expected 1", cap_done[640]); end
        compared++; if (cap_txd[640] !== 1'b1) begin mismatched++; $display("FAIL 8n1_done_txd: got %b expected 1", cap_txd[640]); end
    endtask

    task automatic test_parity();
        logic [7:0] tv [0:2] = '{8'h01, 8'h01, 8'h03};
        logic pkv [0:2] = '{1'b1, 1'b0, 1'b0};
        logic pbv [0:2] = '{1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            logic [31:0] b;
            int nbusy;
            b = {24'h000000, tv[c]};
            nbusy = 0;
            capture(b, 1'b1, pkv[c], 720);
            compared++;
            if (cap_txd[9 * BC + 8] !== pbv[c]) begin
                mismatched++;
                $display("FAIL parity_bit case %0d: got %b expected %b", c, cap_txd[9 * BC + 8], pbv[c]);
            end
            for (int k = 0; k < 720; k++) begin
                compared++;
                if (cap_txd[k] !== exp_txd(k, b, 1'b1, pkv[c])) begin
                    mismatched++;
                    $display("FAIL parity_txd case %0d clk %0d: got %b expected %b", c, k, cap_txd[k], exp_txd(k, b, 1'b1, pkv[c]));
                end
                nbusy += int'(cap_busy[k] === 1'b1);
            end
            compared++; if (nbusy != 704) begin mismatched++; $display("FAIL parity_busy_len case %0d: got %0d expected 704", c, nbusy); end
            compared++; if (cap_done[704] !== 1'b1) begin mismatched++; $display("FAIL parity_done case %0d: got %b expected 1", c, cap_done[704]); end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] want [0:3] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        capture(32'hF00F3CA5, 1'b1, 1'b1, 720);
        for (int j = 0; j < 4; j++) begin
            logic [7:0] r;
            logic p, st;
            for (int i = 0; i < 8; i++) r[i] = cap_txd[(j * 11 + 1 + i) * BC + 8];
            p = cap_txd[(j * 11 + 9) * BC + 8];
            st = cap_txd[(j * 11 + 10) * BC + 8];
            compared++; if (r !== want[j]) begin mismatched++; $display("FAIL loop_r%0d: got %h expected %h", j + 1, r, want[j]); end
            compared++; if ((^{r, p}) !== 1'b1) begin mismatched++; $display("FAIL loop_parity%0d: got bit %b expected odd total", j + 1, p); end
            compared++; if (st !== 1'b1) begin mismatched++; $display("FAIL loop_fr%0d: got %b expected 1", j + 1, st); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] b = 32'h12345678;
        int ndone = 0;
        pulse_k = 100;
        pulse_len = 1;
        pulse_bytes = 32'hDEADBEEF;
        capture(b, 1'b0, 1'b0, 800);
        for (int k = 0; k < 800; k++) begin
            compared++;
            if (cap_txd[k] !== exp_txd(k, b, 1'b0, 1'b0)) begin
                mismatched++;
                $display("FAIL busy_start_txd clk %0d: got %b expected %b", k, cap_txd[k], exp_txd(k, b, 1'b0, 1'b0));
            end
            ndone += int'(cap_done[k] === 1'b1);
        end
        compared++; if (ndone != 1) begin mismatched++; $display("FAIL busy_start_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b = 32'hC3A50033;
        logic [31:0] b2 = 32'h5AA5C33C;
        int ndone = 0;
        rst_k = 14 * BC + 5;
        capture(b, 1'b0, 1'b0, 300);
        for (int k = 0; k < 229; k++) begin
            compared++;
            if (cap_txd[k] !== exp_txd(k, b, 1'b0, 1'b0)) begin
                mismatched++;
                $display("FAIL midrst_pre_txd clk %0d: got %b expected %b", k, cap_txd[k], exp_txd(k, b, 1'b0, 1'b0));
            end
        end
        for (int k = 0; k < 300; k++) ndone += int'(cap_done[k] === 1'b1);
        compared++; if (cap_txd[229] !== 1'b0) begin mismatched++; $display("FAIL midrst_bit3: got %b expected 0", cap_txd[229]); end
        compared++; if (rst_txd !== 1'b1) begin mismatched++; $display("FAIL midrst_txd: got %b expected 1", rst_txd); end
        compared++; if (rst_busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b expected 0", rst_busy); end
        compared++; if (ndone != 0) begin mismatched++; $display("FAIL midrst_done: got %0d expected 0", ndone); end
        rst_n = 1'b1;
        @(negedge clk);
        ndone = 0;
        capture(b2, 1'b0, 1'b0, 660);
        for (int k = 0; k < 660; k++) begin
            compared++;
            if (cap_txd[k] !== exp_txd(k, b2, 1'b0, 1'b0)) begin
                mismatched++;
                $display("FAIL midrst_after_txd clk %0d: got %b expected %b", k, cap_txd[k], exp_txd(k, b2, 1'b0, 1'b0));
            end
            ndone += int'(cap_done[k] === 1'b1);
        end
        compared++; if (ndone != 1 || cap_done[640] !== 1'b1) begin mismatched++; $display("FAIL midrst_after_done: got count %0d expected 1 at clk 640", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b1 = 32'h01020304;
        logic [31:0] b2 = 32'hFEDCBA98;
        int ndone = 0;
        logic e;
        pulse_k = 300;
        pulse_len = 405;
        pulse_bytes = b2;
        capture(b1, 1'b1, 1'b0, 1420);
        for (int k = 0; k < 1420; k++) begin
            e = (k < 705) ? exp_txd(k, b1, 1'b1, 1'b0) : exp_txd(k - 705, b2, 1'b1, 1'b0);
            compared++;
            if (cap_txd[k] !== e) begin
                mismatched++;
                $display("FAIL b2b_txd clk %0d: got %b expected %b", k, cap_txd[k], e);
            end
            ndone += int'(cap_done[k] === 1'b1);
        end
        compared++; if (cap_done[704] !== 1'b1 || cap_busy[704] !== 1'b0) begin mismatched++; $display("FAIL b2b_first_done: got done=%b busy=%b expected 1/0", cap_done[704], cap_busy[704]); end
        compared++; if (cap_busy[705] !== 1'b1) begin mismatched++; $display("FAIL b2b_reaccept: got busy=%b expected 1", cap_busy[705]); end
        compared++; if (cap_done[1409] !== 1'b1) begin mismatched++; $display("FAIL b2b_second_done: got %b expected 1", cap_done[1409]); end
        compared++; if (ndone != 2) begin mismatched++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_loopback();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
